// File: rtl/bfs_sink_engine_pkg.sv
// Shared definitions for the BFS sink engine: cell encoding, FSM states and
// the neighbour offset table (4-connected entries first, diagonals after).
package bfs_pkg;

  localparam logic [1:0] CELL_WATER  = 2'b00;
  localparam logic [1:0] CELL_INTACT = 2'b01;
  localparam logic [1:0] CELL_HIT    = 2'b10;
  localparam logic [1:0] CELL_SUNK   = 2'b11;

  typedef enum logic [3:0] {
    IDLE, SEED, POP, NREQ, NWAIT, EVAL, MARK_REQ, MARK_WAIT, DONE
  } state_t;

  // Order N, E, S, W, NE, SE, SW, NW; y grows downward.
  localparam int NB_DX [8] = '{ 0, 1, 0, -1,  1, 1, -1, -1};
  localparam int NB_DY [8] = '{-1, 0, 1,  0, -1, 1,  1, -1};

endpackage

// File: rtl/bfs_sink_engine_queue.sv
// Synchronous FIFO of packed {x,y} coordinates with a single-cycle clear;
// pop_data always shows the current head entry.
module bfs_queue #(
  parameter int DEPTH = 36,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bfs_sink_engine.sv
// Flood-fills the ship component containing the seed cell, reports whether
// it has no intact cells left (sunk), and optionally rewrites it as sunk.
module bfs_sink_engine
  import bfs_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int HEIGHT    = 6,
  parameter int CW        = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT),
  parameter int DIAG      = 0,
  parameter int MARK_SUNK = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bfs_start,
  input  logic [CW-1:0]                     x,
  input  logic [CW-1:0]                     y,
  output logic [CW-1:0]                     mem_addr_x,
  output logic [CW-1:0]                     mem_addr_y,
  output logic [1:0]                        mem_wr_data,
  output logic                              mem_wr_en,
  output logic                              mem_in_valid,
  input  logic [1:0]                        mem_rd_data,
  input  logic                              mem_ready,
  output logic                              bfs_sink,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] bfs_size,
  output logic                              bfs_busy,
  output logic                              bfs_done
);
  localparam int CELLS  = WIDTH * HEIGHT;
  localparam int IW     = $clog2(CELLS);
  localparam int NUM_NB = (DIAG != 0) ? 8 : 4;

  state_t              state, state_nx;
  logic [CW-1:0]       cur_x, cur_y, nb_x, nb_y, mx, my;
  logic [3:0]          nidx;
  logic [CELLS-1:0]    visited;
  logic                found_intact, pending;
  logic                q_push, q_pop, q_clr, q_empty;
  logic [2*CW-1:0]     q_head, q_in;
  int                  nxi, nyi;
  logic                nb_skip, seed_oob, mark_last, nb_done;

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    return IW'(int'(cy) * WIDTH + int'(cx));
  endfunction

  always_comb begin
    nxi       = int'(cur_x) + NB_DX[nidx[2:0]];
    nyi       = int'(cur_y) + NB_DY[nidx[2:0]];
    nb_done   = (nidx == 4'(NUM_NB));
    // Out-of-bounds short-circuits the visited lookup so a wrapped index is harmless.
    nb_skip   = (nxi < 0) || (nxi >= WIDTH) || (nyi < 0) || (nyi >= HEIGHT) ||
                visited[IW'(nyi * WIDTH + nxi)];
    seed_oob  = (int'(cur_x) >= WIDTH) || (int'(cur_y) >= HEIGHT);
    mark_last = (int'(mx) == WIDTH - 1) && (int'(my) == HEIGHT - 1);
    q_in      = (state == SEED) ? {cur_x, cur_y} : {nb_x, nb_y};
  end

  bfs_queue #(.DEPTH(CELLS), .DW(2*CW)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (q_clr),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .pop_data  (q_head),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output and strobe gets a default first so no path infers a latch.
  always_comb begin
    state_nx     = state;
    mem_in_valid = 1'b0;
    mem_wr_en    = 1'b0;
    mem_wr_data  = CELL_WATER;
    mem_addr_x   = '0;
    mem_addr_y   = '0;
    q_push       = 1'b0;
    q_pop        = 1'b0;
    q_clr        = 1'b0;
    bfs_busy     = (state != IDLE) && (state != DONE);
    bfs_done     = (state == DONE);
    case (state)
      IDLE: if (bfs_start) begin
        q_clr    = 1'b1;
        state_nx = SEED;
      end
      SEED: if (!pending) begin
        if (seed_oob) state_nx = DONE;
        else begin
          mem_in_valid = 1'b1;
          mem_addr_x   = cur_x;
          mem_addr_y   = cur_y;
        end
      end else if (mem_ready) begin
        if (mem_rd_data == CELL_WATER) state_nx = DONE;
        else begin
          q_push   = 1'b1;
          state_nx = POP;
        end
      end
      POP: if (q_empty) state_nx = EVAL;
           else begin
             q_pop    = 1'b1;
             state_nx = NREQ;
           end
      NREQ: if (nb_done) state_nx = POP;
            else if (!nb_skip) begin
              mem_in_valid = 1'b1;
              mem_addr_x   = nxi[CW-1:0];
              mem_addr_y   = nyi[CW-1:0];
              state_nx     = NWAIT;
            end
      NWAIT: if (mem_ready) begin
        q_push   = (mem_rd_data != CELL_WATER);
        state_nx = NREQ;
      end
      EVAL: state_nx = (!found_intact && MARK_SUNK != 0) ? MARK_REQ : DONE;
      MARK_REQ: if (visited[cell_idx(mx, my)]) begin
        mem_in_valid = 1'b1;
        mem_wr_en    = 1'b1;
        mem_wr_data  = CELL_SUNK;
        mem_addr_x   = mx;
        mem_addr_y   = my;
        state_nx     = MARK_WAIT;
      end else if (mark_last) state_nx = DONE;
      MARK_WAIT: if (mem_ready) state_nx = mark_last ? DONE : MARK_REQ;
      DONE: if (!bfs_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x <= '0; cur_y <= '0; nb_x <= '0; nb_y <= '0; mx <= '0; my <= '0;
      nidx <= '0; visited <= '0; found_intact <= 1'b0; pending <= 1'b0;
      bfs_sink <= 1'b0; bfs_size <= '0;
    end else begin
      case (state)
        IDLE: if (bfs_start) begin
          cur_x <= x; cur_y <= y;
          visited <= '0; bfs_size <= '0; found_intact <= 1'b0;
          bfs_sink <= 1'b0; pending <= 1'b0;
        end
        SEED: if (!pending) pending <= !seed_oob;
              else if (mem_ready) begin
                pending <= 1'b0;
                if (mem_rd_data != CELL_WATER) begin
                  visited[cell_idx(cur_x, cur_y)] <= 1'b1;
                  bfs_size     <= 1'b1;
                  found_intact <= (mem_rd_data == CELL_INTACT);
                end
              end
        POP: if (!q_empty) begin
          {cur_x, cur_y} <= q_head;
          nidx           <= '0;
        end
        NREQ: if (!nb_done) begin
          nidx <= nidx + 1'b1;
          if (!nb_skip) begin
            nb_x <= nxi[CW-1:0];
            nb_y <= nyi[CW-1:0];
          end
        end
        NWAIT: if (mem_ready && mem_rd_data != CELL_WATER) begin
          visited[cell_idx(nb_x, nb_y)] <= 1'b1;
          bfs_size <= bfs_size + 1'b1;
          if (mem_rd_data == CELL_INTACT) found_intact <= 1'b1;
        end
        EVAL: begin
          bfs_sink <= !found_intact;
          mx <= '0;
          my <= '0;
        end
        MARK_REQ, MARK_WAIT:
          if ((state == MARK_REQ && !visited[cell_idx(mx, my)]) ||
              (state == MARK_WAIT && mem_ready)) begin
            if (int'(mx) == WIDTH - 1) begin
              mx <= '0;
              my <= my + 1'b1;
            end else mx <= mx + 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bfs_sink_engine.sv
// Directed bench: three engine configurations share one reset and a 2-cycle
// latency grid memory model that logs accesses, writes and protocol errors.
module tb_bfs_sink_engine;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       bfs_start [N];
  logic [2:0] x [N], y [N];
  logic [2:0] ax [N], ay [N];
  logic [1:0] wd [N], rd [N];
  logic       we [N], iv [N], rdy [N];
  logic       sink [N], busy [N], done [N];
  logic [5:0] size [N];

  logic [1:0]  grid [N][64];
  int          n_acc [N], n_wr [N], viol [N], cnt [N], pa [N];
  logic [2:0]  max_y [N];
  logic [95:0] wlog [N];

  int         checks = 0, errors = 0;
  logic       r_sink;
  logic [5:0] r_size;
  int         acc0, wr0;

  bfs_sink_engine #(.WIDTH(6), .HEIGHT(6), .DIAG(0)) u0 (
    .clk(clk), .rst(rst), .bfs_start(bfs_start[0]), .x(x[0]), .y(y[0]),
    .mem_addr_x(ax[0]), .mem_addr_y(ay[0]), .mem_wr_data(wd[0]), .mem_wr_en(we[0]),
    .mem_in_valid(iv[0]), .mem_rd_data(rd[0]), .mem_ready(rdy[0]),
    .bfs_sink(sink[0]), .bfs_size(size[0]), .bfs_busy(busy[0]), .bfs_done(done[0]));
  bfs_sink_engine #(.WIDTH(6), .HEIGHT(6), .DIAG(1)) u1 (
    .clk(clk), .rst(rst), .bfs_start(bfs_start[1]), .x(x[1]), .y(y[1]),
    .mem_addr_x(ax[1]), .mem_addr_y(ay[1]), .mem_wr_data(wd[1]), .mem_wr_en(we[1]),
    .mem_in_valid(iv[1]), .mem_rd_data(rd[1]), .mem_ready(rdy[1]),
    .bfs_sink(sink[1]), .bfs_size(size[1]), .bfs_busy(busy[1]), .bfs_done(done[1]));
  bfs_sink_engine #(.WIDTH(8), .HEIGHT(4), .DIAG(0)) u2 (
    .clk(clk), .rst(rst), .bfs_start(bfs_start[2]), .x(x[2]), .y(y[2]),
    .mem_addr_x(ax[2]), .mem_addr_y(ay[2]), .mem_wr_data(wd[2]), .mem_wr_en(we[2]),
    .mem_in_valid(iv[2]), .mem_rd_data(rd[2]), .mem_ready(rdy[2]),
    .bfs_sink(sink[2]), .bfs_size(size[2]), .bfs_busy(busy[2]), .bfs_done(done[2]));

  // Memory model: samples strobes mid-cycle, answers two cycles later.
  initial begin
    for (int g = 0; g < N; g++) begin
      cnt[g] = 0; rdy[g] = 1'b0; rd[g] = 2'b00; pa[g] = 0;
      n_acc[g] = 0; n_wr[g] = 0; viol[g] = 0; max_y[g] = 3'd0; wlog[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        rdy[g] = 1'b0;
        if (rst) cnt[g] = 0;
        else begin
          if (cnt[g] > 0) begin
            cnt[g]--;
            if (cnt[g] == 0) begin
              rdy[g] = 1'b1;
              rd[g]  = grid[g][pa[g]];
            end
          end
          if (we[g] && !iv[g]) viol[g]++;
          if (iv[g]) begin
            if (cnt[g] > 0 || rdy[g]) viol[g]++;
            n_acc[g]++;
            if (ay[g] > max_y[g]) max_y[g] = ay[g];
            pa[g] = int'(ay[g]) * 8 + int'(ax[g]);
            if (we[g]) begin
              if (wd[g] != 2'b11) viol[g]++;
              wlog[g][6*(n_wr[g] % 16) +: 6] = {ax[g], ay[g]};
              n_wr[g]++;
            end
            cnt[g] = 2;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic clear_grid();
    for (int g = 0; g < N; g++)
      for (int i = 0; i < 64; i++) grid[g][i] = 2'b00;
  endtask

  task automatic set_cell(input int g, input int cx, input int cy, input logic [1:0] v);
    grid[g][cy*8 + cx] = v;
  endtask

  task automatic run(input int g, input int sx, input int sy);
    int k;
    acc0 = n_acc[g];
    wr0  = n_wr[g];
    @(negedge clk);
    x[g] = 3'(sx); y[g] = 3'(sy); bfs_start[g] = 1'b1;
    k = 0;
    while (!done[g] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!done[g]) begin
      checks++; errors++;
      $display("FAIL run_timeout inst %0d: done=%b, required 1", g, done[g]);
    end
    r_sink = sink[g];
    r_size = size[g];
    bfs_start[g] = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic check_sink_mark_run(input string tag);
    logic [5:0] exp_w [3];
    logic [5:0] got;
    exp_w[0] = {3'd1, 3'd1}; exp_w[1] = {3'd2, 3'd1}; exp_w[2] = {3'd1, 3'd2};
    run(0, 1, 1);
    checks++;
    if ({r_sink, r_size} !== {1'b1, 6'd3}) begin
      errors++;
      $display("FAIL %s_result: sink=%0d size=%0d, required sink=1 size=3", tag, r_sink, r_size);
    end
    checks++;
    if (n_acc[0] - acc0 !== 14 || n_wr[0] - wr0 !== 3) begin
      errors++;
      $display("FAIL %s_counts: accesses=%0d writes=%0d, required 14 and 3", tag, n_acc[0]-acc0, n_wr[0]-wr0);
    end
    for (int i = 0; i < 3; i++) begin
      got = wlog[0][6*((wr0 + i) % 16) +: 6];
      checks++;
      if (got !== exp_w[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got (%0d,%0d), required (%0d,%0d)", tag, i,
                 got[5:3], got[2:0], exp_w[i][5:3], exp_w[i][2:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      checks++;
      if ({busy[g], done[g], iv[g], we[g], sink[g], size[g], ax[g], ay[g]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d: busy=%b done=%b iv=%b we=%b sink=%b size=%0d, required all 0",
                 g, busy[g], done[g], iv[g], we[g], sink[g], size[g]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_intact();
    clear_grid();
    set_cell(0, 1, 1, 2'b10); set_cell(0, 2, 1, 2'b01); set_cell(0, 1, 2, 2'b10);
    run(0, 1, 1);
    checks++;
    if ({r_sink, r_size} !== {1'b0, 6'd3}) begin
      errors++;
      $display("FAIL intact_result: sink=%0d size=%0d, required sink=0 size=3", r_sink, r_size);
    end
    checks++;
    if (n_acc[0] - acc0 !== 11 || n_wr[0] - wr0 !== 0) begin
      errors++;
      $display("FAIL intact_counts: accesses=%0d writes=%0d, required 11 and 0", n_acc[0]-acc0, n_wr[0]-wr0);
    end
  endtask

  task automatic test_sink_mark();
    set_cell(0, 2, 1, 2'b10);
    check_sink_mark_run("sink_mark");
  endtask

  task automatic test_water_and_oob();
    run(0, 0, 0);
    checks++;
    if ({r_sink, r_size} !== 7'd0 || n_acc[0] - acc0 !== 1) begin
      errors++;
      $display("FAIL water_seed: sink=%0d size=%0d accesses=%0d, required 0 0 1", r_sink, r_size, n_acc[0]-acc0);
    end
    run(0, 1, 1);
    run(0, 6, 0);
    checks++;
    if ({r_sink, r_size} !== 7'd0 || n_acc[0] - acc0 !== 0) begin
      errors++;
      $display("FAIL oob_seed: sink=%0d size=%0d accesses=%0d, required 0 0 0", r_sink, r_size, n_acc[0]-acc0);
    end
  endtask

  task automatic test_diag();
    clear_grid();
    for (int g = 0; g < 2; g++) begin
      set_cell(g, 1, 1, 2'b10); set_cell(g, 2, 2, 2'b10);
    end
    run(0, 1, 1);
    checks++;
    if ({r_sink, r_size} !== {1'b1, 6'd1}) begin
      errors++;
      $display("FAIL diag0_result: sink=%0d size=%0d, required sink=1 size=1", r_sink, r_size);
    end
    run(1, 1, 1);
    checks++;
    if ({r_sink, r_size} !== {1'b1, 6'd2} || n_wr[1] - wr0 !== 2) begin
      errors++;
      $display("FAIL diag1_result: sink=%0d size=%0d writes=%0d, required 1 2 2", r_sink, r_size, n_wr[1]-wr0);
    end
  endtask

  task automatic test_wide_grid();
    for (int i = 0; i < 8; i++) set_cell(2, i, 3, 2'b10);
    run(2, 7, 3);
    checks++;
    if ({r_sink, r_size} !== {1'b1, 6'd8}) begin
      errors++;
      $display("FAIL wide_result: sink=%0d size=%0d, required sink=1 size=8", r_sink, r_size);
    end
    checks++;
    if (n_acc[2] - acc0 !== 24 || n_wr[2] - wr0 !== 8 || max_y[2] > 3'd3) begin
      errors++;
      $display("FAIL wide_counts: accesses=%0d writes=%0d max_y=%0d, required 24 8 <=3",
               n_acc[2]-acc0, n_wr[2]-wr0, max_y[2]);
    end
  endtask

  task automatic test_done_handshake();
    int k;
    clear_grid();
    set_cell(0, 1, 1, 2'b10); set_cell(0, 2, 1, 2'b01); set_cell(0, 1, 2, 2'b10);
    @(negedge clk);
    x[0] = 3'd1; y[0] = 3'd1; bfs_start[0] = 1'b1;
    repeat (3) @(negedge clk);
    x[0] = 3'd5; y[0] = 3'd5;
    k = 0;
    while (!done[0] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({done[0], busy[0], sink[0], size[0]} !== {1'b1, 1'b0, 1'b0, 6'd3}) begin
      errors++;
      $display("FAIL done_hold: done=%b busy=%b sink=%0d size=%0d, required 1 0 0 3",
               done[0], busy[0], sink[0], size[0]);
    end
    bfs_start[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({done[0], busy[0]} !== 2'b00) begin
      errors++;
      $display("FAIL done_release: done=%b busy=%b, required 0 0", done[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_search();
    int k;
    set_cell(0, 2, 1, 2'b10);
    acc0 = n_acc[0];
    @(negedge clk);
    x[0] = 3'd1; y[0] = 3'd1; bfs_start[0] = 1'b1;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (n_acc[0] - acc0 < 2 && k < 200);
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b1 || n_acc[0] - acc0 !== 2) begin
      errors++;
      $display("FAIL pre_reset_busy: busy=%b accesses=%0d, required 1 2", busy[0], n_acc[0]-acc0);
    end
    rst = 1'b1;
    bfs_start[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy[0], done[0], iv[0], we[0], sink[0], size[0], ax[0], ay[0]} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b iv=%b we=%b sink=%b size=%0d, required all 0",
               busy[0], done[0], iv[0], we[0], sink[0], size[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_sink_mark_run("rerun");
    checks++;
    if (viol[0] + viol[1] + viol[2] !== 0) begin
      errors++;
      $display("FAIL protocol: violations=%0d, required 0", viol[0] + viol[1] + viol[2]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      bfs_start[g] = 1'b0; x[g] = 3'd0; y[g] = 3'd0;
    end
    clear_grid();
    test_reset();
    test_intact();
    test_sink_mark();
    test_water_and_oob();
    test_diag();
    test_wide_grid();
    test_done_handshake();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfs_sink_engine.md
BFS_SINK_ENGINE -- requirements
Module: bfs_sink_engine

Interface
REQ-001 Parameter WIDTH, 6, grid columns (>=2).
REQ-002 Parameter HEIGHT, 6, grid rows (>=2).
REQ-003 Parameter CW, $clog2(max(WIDTH,HEIGHT)), coordinate width.
REQ-004 Parameter DIAG, 0, 0 = 4-connected, 1 = 8-connected.
REQ-005 Parameter MARK_SUNK, 1, 1 = rewrite a sunk component to CELL_SUNK.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 bfs_start  in  1  level request, sampled only in IDLE.
REQ-009 x, y  in  CW  seed coordinate, captured with bfs_start.
REQ-010 mem_addr_x, mem_addr_y  out  CW  cell address.
REQ-011 mem_wr_data  out  2  write value; mem_wr_en  out  1  write qualifier.
REQ-012 mem_in_valid  out  1  one-cycle access strobe; mem_rd_data  in  2; mem_ready  in  1 (read data valid).
REQ-013 bfs_sink  out  1; bfs_size  out  $clog2(WIDTH*HEIGHT+1); bfs_busy  out  1; bfs_done  out  1.

Function
REQ-014 Cell encoding: 00 water, 01 ship intact, 10 ship hit, 11 ship sunk; non-water cells form components.
REQ-015 States: IDLE, SEED, POP, NREQ, NWAIT, EVAL, MARK_REQ, MARK_WAIT, DONE.
REQ-016 IDLE: bfs_start=1 captures x,y, clears visited bitmap, size, found_intact and queue in one cycle, goes to SEED; bfs_busy=1 in every state except IDLE and DONE.
REQ-017 Seed out of range (x>=WIDTH or y>=HEIGHT): no memory access, go to DONE with sink=0, size=0.
REQ-018 Every access: mem_in_valid high exactly one cycle, then wait (in_valid low) until mem_ready; no second access outstanding.
REQ-019 SEED reads seed; 00 -> DONE with sink=0,size=0; else mark visited, push, size=1, found_intact=(data==01).
REQ-020 POP: pop head; neighbour order N,E,S,W then (DIAG=1) NE,SE,SW,NW; skip out-of-bounds or visited neighbours without a memory access.
REQ-021 NWAIT on ready: data!=00 -> mark visited, push, size+1, data==01 sets found_intact.
REQ-022 Queue empty after last neighbour -> EVAL: bfs_sink = !found_intact.
REQ-023 EVAL: sink=1 and MARK_SUNK=1 -> MARK_REQ; else DONE.
REQ-024 MARK: sweep visited bitmap in raster order (y outer, x inner), one write of 11 per visited cell, mem_wr_en=1 with in_valid, wait ready each write.
REQ-025 DONE: bfs_done=1, sink/size stable; return to IDLE only when bfs_start=0; done deasserts same cycle.
REQ-026 Queue depth WIDTH*HEIGHT; each cell pushed at most once, so no overflow; mem_wr_en=0 outside MARK.
REQ-027 bfs_start changes while busy are ignored.

Reset
REQ-028 rst=1 asynchronously forces IDLE; all outputs 0; visited, queue, size, found_intact cleared; an in-flight mem_ready is ignored.
REQ-029 Reset mid-search or mid-MARK abandons work; partial marks are not undone.

Structure
REQ-030 Package bfs_pkg holds cell-encoding constants, state enum, neighbour dx/dy table.
REQ-031 Sub-module bfs_queue: synchronous FIFO (push, pop, empty, parametrised depth/width) holding {x,y}.

Verification
REQ-032 6x6, DIAG=0; (1,1)=10,(2,1)=01,(1,2)=10; seed (1,1) -> sink=0, size=3, no writes.
REQ-033 Same grid, (2,1)=10 -> sink=1, size=3; writes 11 to (1,1),(2,1),(1,2) in that order.
REQ-034 Seed (0,0) water -> done, sink=0, size=0, one read only; seed (6,0) -> done, zero accesses.
REQ-035 (1,1)=10,(2,2)=10: DIAG=0 -> size=1, sink=1; DIAG=1 -> size=2, sink=1.
REQ-036 WIDTH=8, HEIGHT=4, full row y=3 hit, seed (7,3) -> size=8, sink=1; no address with x>7 or y>3 issued.
REQ-037 Assert rst during NWAIT -> next cycle outputs 0, IDLE; rerun of REQ-033 yields identical results.
